// File: rtl/sdcard_init_sequencer.sv
// SD card identification/initialisation sequencer: drives the command engine through
// CMD0, CMD8, CMD55/ACMD41 polling, CMD2, CMD3 and CMD7, then reports the card's identity.
module sdcard_init_sequencer #(
  parameter int unsigned MAX_ACMD41_TRIES = 1000,
  parameter int unsigned GAP_CYCLES       = 8,
  parameter int unsigned WDOG_CYCLES      = 65535,
  parameter logic [7:0]  CHECK_PATTERN    = 8'hAA
) (
  input  logic        PCLK_i,
  input  logic        PRESET_i,
  input  logic        init_start_i,
  output logic        init_busy_o,
  output logic        init_done_o,
  output logic        init_error_o,
  output logic [3:0]  err_code_o,
  output logic        card_hc_o,
  output logic        card_v2_o,
  output logic [15:0] card_rca_o,
  output logic [31:0] ocr_o,
  output logic [5:0]  cmd_index_o,
  output logic [31:0] cmd_argument_o,
  output logic        cmd_start_o,
  input  logic        cmd_busy_i,
  input  logic        cmd_done_i,
  input  logic        cmd_timeout_i,
  input  logic        cmd_crc_error_i,
  input  logic [39:0] cmd_response_i
);

  localparam logic [2:0] ST_IDLE  = 3'd0;
  localparam logic [2:0] ST_GAP   = 3'd1;
  localparam logic [2:0] ST_ISSUE = 3'd2;
  localparam logic [2:0] ST_WAIT  = 3'd3;
  localparam logic [2:0] ST_EVAL  = 3'd4;
  localparam logic [2:0] ST_DONE  = 3'd5;
  localparam logic [2:0] ST_ERROR = 3'd6;

  localparam logic [2:0] STEP_CMD0   = 3'd0;
  localparam logic [2:0] STEP_CMD8   = 3'd1;
  localparam logic [2:0] STEP_CMD55  = 3'd2;
  localparam logic [2:0] STEP_ACMD41 = 3'd3;
  localparam logic [2:0] STEP_CMD2   = 3'd4;
  localparam logic [2:0] STEP_CMD3   = 3'd5;
  localparam logic [2:0] STEP_CMD7   = 3'd6;

  localparam logic [1:0] OC_DONE    = 2'd0;
  localparam logic [1:0] OC_CRC     = 2'd1;
  localparam logic [1:0] OC_TIMEOUT = 2'd2;

  logic [2:0]  state_q, state_d;
  logic [2:0]  step_q, step_d;
  logic [31:0] cnt_q, cnt_d;
  logic [15:0] tries_q, tries_d;
  logic [1:0]  outcome_q, outcome_d;
  logic [31:0] payload_q, payload_d;
  logic        busy_q, busy_d;
  logic        done_q, done_d;
  logic        error_q, error_d;
  logic [3:0]  err_code_q, err_code_d;
  logic        hc_q, hc_d;
  logic        v2_q, v2_d;
  logic [15:0] rca_q, rca_d;
  logic [31:0] ocr_q, ocr_d;
  logic [5:0]  cmd_index_q, cmd_index_d;
  logic [31:0] cmd_argument_q, cmd_argument_d;
  logic        cmd_start_q, cmd_start_d;

  logic        fail, advance;
  logic [3:0]  fail_code;
  logic [2:0]  next_step;
  logic [5:0]  issue_index;
  logic [31:0] issue_arg;

  // The engine's busy flag and the response framing byte carry nothing we act on.
  logic unused_inputs;
  assign unused_inputs = ^{cmd_busy_i, cmd_response_i[7:0]};

  always_comb begin
    issue_index = 6'd0;
    issue_arg   = 32'h0;
    case (step_q)
      STEP_CMD0:   issue_index = 6'd0;
      STEP_CMD8:   begin issue_index = 6'd8; issue_arg = {20'h0, 4'h1, CHECK_PATTERN}; end
      STEP_CMD55:  issue_index = 6'd55;
      STEP_ACMD41: begin issue_index = 6'd41; issue_arg = v2_q ? 32'h40FF_8000 : 32'h00FF_8000; end
      STEP_CMD2:   issue_index = 6'd2;
      STEP_CMD3:   issue_index = 6'd3;
      STEP_CMD7:   begin issue_index = 6'd7; issue_arg = {rca_q, 16'h0}; end
      default:     issue_index = 6'd0;
    endcase
  end

  always_comb begin
    state_d        = state_q;
    step_d         = step_q;
    cnt_d          = cnt_q;
    tries_d        = tries_q;
    outcome_d      = outcome_q;
    payload_d      = payload_q;
    busy_d         = busy_q;
    done_d         = 1'b0;
    error_d        = 1'b0;
    err_code_d     = err_code_q;
    hc_d           = hc_q;
    v2_d           = v2_q;
    rca_d          = rca_q;
    ocr_d          = ocr_q;
    cmd_index_d    = cmd_index_q;
    cmd_argument_d = cmd_argument_q;
    cmd_start_d    = 1'b0;
    fail           = 1'b0;
    fail_code      = 4'd0;
    advance        = 1'b0;
    next_step      = step_q;

    case (state_q)
      ST_IDLE: begin
        if (init_start_i) begin
          err_code_d = 4'd0;
          hc_d       = 1'b0;
          v2_d       = 1'b0;
          rca_d      = 16'h0;
          ocr_d      = 32'h0;
          tries_d    = 16'h0;
          cnt_d      = 32'h0;
          step_d     = STEP_CMD0;
          busy_d     = 1'b1;
          state_d    = ST_GAP;
        end
      end
      ST_GAP: begin
        if (cnt_q + 32'd1 >= 32'(GAP_CYCLES)) begin
          cnt_d          = 32'h0;
          cmd_index_d    = issue_index;
          cmd_argument_d = issue_arg;
          cmd_start_d    = 1'b1;
          state_d        = ST_ISSUE;
        end else begin
          cnt_d = cnt_q + 32'd1;
        end
      end
      ST_ISSUE: state_d = ST_WAIT;
      ST_WAIT: begin
        if (cmd_timeout_i || cmd_crc_error_i || cmd_done_i) begin
          if (cmd_timeout_i)        outcome_d = OC_TIMEOUT;
          else if (cmd_crc_error_i) outcome_d = OC_CRC;
          else                      outcome_d = OC_DONE;
          payload_d = cmd_response_i[39:8];
          cnt_d     = 32'h0;
          state_d   = ST_EVAL;
        end else if (cnt_q + 32'd1 >= 32'(WDOG_CYCLES)) begin
          fail      = 1'b1;
          fail_code = 4'd7;
        end else begin
          cnt_d = cnt_q + 32'd1;
        end
      end
      ST_EVAL: begin
        case (step_q)
          STEP_CMD0: begin advance = 1'b1; next_step = STEP_CMD8; end
          STEP_CMD8: begin
            if (outcome_q == OC_TIMEOUT) begin
              v2_d = 1'b0; advance = 1'b1; next_step = STEP_CMD55;
            end else if (outcome_q == OC_CRC) begin
              fail = 1'b1; fail_code = 4'd3;
            end else if (payload_q[7:0] == CHECK_PATTERN && payload_q[11:8] == 4'h1) begin
              v2_d = 1'b1; advance = 1'b1; next_step = STEP_CMD55;
            end else begin
              fail = 1'b1; fail_code = 4'd2;
            end
          end
          STEP_CMD55: begin
            if (outcome_q == OC_TIMEOUT)  begin fail = 1'b1; fail_code = 4'd5; end
            else if (outcome_q == OC_CRC) begin fail = 1'b1; fail_code = 4'd6; end
            else begin advance = 1'b1; next_step = STEP_ACMD41; end
          end
          STEP_ACMD41: begin
            // R3 has no valid CRC, so a CRC flag still delivers a usable OCR.
            if (outcome_q == OC_TIMEOUT) begin
              fail = 1'b1; fail_code = 4'd5;
            end else begin
              ocr_d = payload_q;
              if (payload_q[31]) begin
                hc_d = payload_q[30]; advance = 1'b1; next_step = STEP_CMD2;
              end else begin
                tries_d = tries_q + 16'd1;
                if (tries_q + 16'd1 == 16'(MAX_ACMD41_TRIES)) begin
                  fail = 1'b1; fail_code = 4'd4;
                end else begin
                  advance = 1'b1; next_step = STEP_CMD55;
                end
              end
            end
          end
          STEP_CMD2: begin
            if (outcome_q == OC_TIMEOUT) begin fail = 1'b1; fail_code = 4'd5; end
            else begin advance = 1'b1; next_step = STEP_CMD3; end
          end
          STEP_CMD3: begin
            if (outcome_q == OC_TIMEOUT)  begin fail = 1'b1; fail_code = 4'd5; end
            else if (outcome_q == OC_CRC) begin fail = 1'b1; fail_code = 4'd6; end
            else begin rca_d = payload_q[31:16]; advance = 1'b1; next_step = STEP_CMD7; end
          end
          STEP_CMD7: begin
            if (outcome_q == OC_TIMEOUT)  begin fail = 1'b1; fail_code = 4'd5; end
            else if (outcome_q == OC_CRC) begin fail = 1'b1; fail_code = 4'd6; end
            else begin done_d = 1'b1; state_d = ST_DONE; end
          end
          default: begin busy_d = 1'b0; state_d = ST_IDLE; end
        endcase
      end
      ST_DONE, ST_ERROR: begin
        busy_d  = 1'b0;
        state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase

    if (advance) begin
      step_d  = next_step;
      state_d = ST_GAP;
    end
    if (fail) begin
      err_code_d = fail_code;
      error_d    = 1'b1;
      state_d    = ST_ERROR;
    end
  end

  always_ff @(posedge PCLK_i) begin
    if (PRESET_i) begin
      state_q        <= ST_IDLE;
      step_q         <= STEP_CMD0;
      cnt_q          <= 32'h0;
      tries_q        <= 16'h0;
      outcome_q      <= OC_DONE;
      payload_q      <= 32'h0;
      busy_q         <= 1'b0;
      done_q         <= 1'b0;
      error_q        <= 1'b0;
      err_code_q     <= 4'd0;
      hc_q           <= 1'b0;
      v2_q           <= 1'b0;
      rca_q          <= 16'h0;
      ocr_q          <= 32'h0;
      cmd_index_q    <= 6'd0;
      cmd_argument_q <= 32'h0;
      cmd_start_q    <= 1'b0;
    end else begin
      state_q        <= state_d;
      step_q         <= step_d;
      cnt_q          <= cnt_d;
      tries_q        <= tries_d;
      outcome_q      <= outcome_d;
      payload_q      <= payload_d;
      busy_q         <= busy_d;
      done_q         <= done_d;
      error_q        <= error_d;
      err_code_q     <= err_code_d;
      hc_q           <= hc_d;
      v2_q           <= v2_d;
      rca_q          <= rca_d;
      ocr_q          <= ocr_d;
      cmd_index_q    <= cmd_index_d;
      cmd_argument_q <= cmd_argument_d;
      cmd_start_q    <= cmd_start_d;
    end
  end

  assign init_busy_o    = busy_q;
  assign init_done_o    = done_q;
  assign init_error_o   = error_q;
  assign err_code_o     = err_code_q;
  assign card_hc_o      = hc_q;
  assign card_v2_o      = v2_q;
  assign card_rca_o     = rca_q;
  assign ocr_o          = ocr_q;
  assign cmd_index_o    = cmd_index_q;
  assign cmd_argument_o = cmd_argument_q;
  assign cmd_start_o    = cmd_start_q;

endmodule

// File: tb/tb_sdcard_init_sequencer.sv
// Directed bench for sdcard_init_sequencer: a scripted command-engine responder driven
// from per-scenario step tables, plus hand-written reset, watchdog and restart sequences.
module tb_sdcard_init_sequencer;

  localparam int MAX_TRIES = 3;
  localparam int GAP       = 8;
  localparam int WDOG      = 40;

  localparam logic [2:0] K_DONE    = 3'd0;
  localparam logic [2:0] K_CRC     = 3'd1;
  localparam logic [2:0] K_TO      = 3'd2;
  localparam logic [2:0] K_TO_DONE = 3'd3;
  localparam logic [2:0] K_SILENT  = 3'd4;

  logic        PCLK_i = 1'b0;
  logic        PRESET_i;
  logic        init_start_i;
  logic        init_busy_o, init_done_o, init_error_o;
  logic [3:0]  err_code_o;
  logic        card_hc_o, card_v2_o;
  logic [15:0] card_rca_o;
  logic [31:0] ocr_o;
  logic [5:0]  cmd_index_o;
  logic [31:0] cmd_argument_o;
  logic        cmd_start_o;
  logic        cmd_busy_i, cmd_done_i, cmd_timeout_i, cmd_crc_error_i;
  logic [39:0] cmd_response_i;

  typedef struct {
    logic [2:0]  kind;
    logic [31:0] payload;
    logic [5:0]  exp_idx;
    logic [31:0] exp_arg;
  } step_rec_t;

  step_rec_t vecs[$];
  int checks = 0;
  int errors = 0;

  sdcard_init_sequencer #(
    .MAX_ACMD41_TRIES(MAX_TRIES),
    .GAP_CYCLES(GAP),
    .WDOG_CYCLES(WDOG),
    .CHECK_PATTERN(8'hAA)
  ) dut (
    .PCLK_i(PCLK_i), .PRESET_i(PRESET_i), .init_start_i(init_start_i),
    .init_busy_o(init_busy_o), .init_done_o(init_done_o), .init_error_o(init_error_o),
    .err_code_o(err_code_o), .card_hc_o(card_hc_o), .card_v2_o(card_v2_o),
    .card_rca_o(card_rca_o), .ocr_o(ocr_o), .cmd_index_o(cmd_index_o),
    .cmd_argument_o(cmd_argument_o), .cmd_start_o(cmd_start_o), .cmd_busy_i(cmd_busy_i),
    .cmd_done_i(cmd_done_i), .cmd_timeout_i(cmd_timeout_i), .cmd_crc_error_i(cmd_crc_error_i),
    .cmd_response_i(cmd_response_i)
  );

  always #5 PCLK_i = ~PCLK_i;

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got %h, expected %h", name, actual, expected);
    end
  endtask

  task automatic checkRange(input string name, input int actual, input int lo, input int hi);
    checks++;
    if (actual < lo || actual > hi) begin
      errors++;
      $display("[TB] FAIL %s: got %0d, expected %0d..%0d", name, actual, lo, hi);
    end
  endtask

  task automatic addStep(input logic [2:0] kind, input logic [31:0] payload,
                         input logic [5:0] idx, input logic [31:0] arg);
    step_rec_t r;
    r.kind = kind; r.payload = payload; r.exp_idx = idx; r.exp_arg = arg;
    vecs.push_back(r);
  endtask

  task automatic startInit();
    @(negedge PCLK_i) init_start_i = 1'b1;
    @(negedge PCLK_i) init_start_i = 1'b0;
  endtask

  task automatic waitStart(output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 300; i++) begin
      @(negedge PCLK_i);
      if (cmd_start_o) begin ok = 1'b1; break; end
    end
  endtask

  // Walk the step table: check each issued command, then play the scripted engine reply.
  task automatic applyStimulus();
    bit ok;
    foreach (vecs[i]) begin
      waitStart(ok);
      if (!ok) begin
        checks++; errors++;
        $display("[TB] FAIL cmd_start[%0d]: got no start, expected index %0d", i, vecs[i].exp_idx);
        break;
      end
      checkOutput($sformatf("cmd_index[%0d]", i), 32'(cmd_index_o), 32'(vecs[i].exp_idx));
      checkOutput($sformatf("cmd_argument[%0d]", i), cmd_argument_o, vecs[i].exp_arg);
      @(negedge PCLK_i);
      checkOutput($sformatf("cmd_start_width[%0d]", i), 32'(cmd_start_o), 32'd0);
      if (vecs[i].kind != K_SILENT) begin
        @(negedge PCLK_i);
        cmd_response_i  = {vecs[i].payload, 8'h01};
        cmd_done_i      = (vecs[i].kind == K_DONE) || (vecs[i].kind == K_TO_DONE);
        cmd_crc_error_i = (vecs[i].kind == K_CRC);
        cmd_timeout_i   = (vecs[i].kind == K_TO) || (vecs[i].kind == K_TO_DONE);
        @(negedge PCLK_i);
        cmd_done_i = 1'b0; cmd_crc_error_i = 1'b0; cmd_timeout_i = 1'b0;
        cmd_response_i = 40'h0;
      end
    end
    vecs.delete();
  endtask

  task automatic checkResult(input string tag, input bit exp_done, input logic [3:0] exp_code,
                             output int cycles);
    bit got_done, got_err;
    got_done = 1'b0; got_err = 1'b0; cycles = -1;
    for (int i = 1; i <= 400; i++) begin
      @(negedge PCLK_i);
      if (init_done_o || init_error_o) begin
        got_done = init_done_o; got_err = init_error_o; cycles = i;
        break;
      end
    end
    checkOutput({tag, "_done_pulse"}, 32'(got_done), 32'(exp_done));
    checkOutput({tag, "_error_pulse"}, 32'(got_err), 32'(!exp_done));
    checkOutput({tag, "_err_code"}, 32'(err_code_o), 32'(exp_code));
    @(negedge PCLK_i);
    checkOutput({tag, "_pulse_width"}, 32'({init_done_o, init_error_o}), 32'd0);
    checkOutput({tag, "_busy_after"}, 32'(init_busy_o), 32'd0);
  endtask

  task automatic checkNoStarts(input string tag, input int n);
    int starts;
    starts = 0;
    for (int i = 0; i < n; i++) begin
      @(negedge PCLK_i);
      if (cmd_start_o) starts++;
    end
    checkOutput({tag, "_extra_starts"}, 32'(starts), 32'd0);
  endtask

  initial begin
    #2_000_000;
    $display("[TB] FAIL global_timeout: got no completion, expected $finish");
    $fatal(1, "[TB] simulation time limit");
  end

  initial begin
    int cycles;
    int pulses;
    PRESET_i = 1'b1; init_start_i = 1'b0; cmd_busy_i = 1'b0;
    cmd_done_i = 1'b0; cmd_timeout_i = 1'b0; cmd_crc_error_i = 1'b0; cmd_response_i = 40'h0;
    repeat (3) @(negedge PCLK_i);
    checkOutput("reset_flags", 32'({init_busy_o, init_done_o, init_error_o, cmd_start_o, card_hc_o, card_v2_o}), 32'd0);
    checkOutput("reset_index_arg", cmd_argument_o | 32'(cmd_index_o), 32'd0);
    checkOutput("reset_ocr_rca_code", ocr_o | 32'(card_rca_o) | 32'(err_code_o), 32'd0);
    PRESET_i = 1'b0;

    $display("[TB] scenario: v2 high-capacity card");
    startInit();
    addStep(K_TO,   32'h0,          6'd0,  32'h0);
    addStep(K_DONE, 32'h0000_01AA,  6'd8,  32'h0000_01AA);
    addStep(K_DONE, 32'h0000_0120,  6'd55, 32'h0);
    addStep(K_DONE, 32'h00FF_8000,  6'd41, 32'h40FF_8000);
    addStep(K_DONE, 32'h0000_0120,  6'd55, 32'h0);
    addStep(K_DONE, 32'h00FF_8000,  6'd41, 32'h40FF_8000);
    addStep(K_DONE, 32'h0000_0120,  6'd55, 32'h0);
    addStep(K_CRC,  32'hC0FF_8000,  6'd41, 32'h40FF_8000);
    addStep(K_CRC,  32'hDEAD_BEEF,  6'd2,  32'h0);
    addStep(K_DONE, 32'h1234_0500,  6'd3,  32'h0);
    addStep(K_DONE, 32'h0000_0900,  6'd7,  32'h1234_0000);
    applyStimulus();
    checkResult("v2hc", 1'b1, 4'd0, cycles);
    checkOutput("v2hc_card_hc", 32'(card_hc_o), 32'd1);
    checkOutput("v2hc_card_v2", 32'(card_v2_o), 32'd1);
    checkOutput("v2hc_rca", 32'(card_rca_o), 32'h1234);
    checkOutput("v2hc_ocr", ocr_o, 32'hC0FF_8000);

    $display("[TB] scenario: v1 standard-capacity card");
    startInit();
    addStep(K_DONE, 32'h0,          6'd0,  32'h0);
    addStep(K_TO,   32'h0,          6'd8,  32'h0000_01AA);
    addStep(K_DONE, 32'h0000_0120,  6'd55, 32'h0);
    addStep(K_DONE, 32'h80FF_8000,  6'd41, 32'h00FF_8000);
    addStep(K_DONE, 32'h0,          6'd2,  32'h0);
    addStep(K_DONE, 32'hABCD_0000,  6'd3,  32'h0);
    addStep(K_DONE, 32'h0,          6'd7,  32'hABCD_0000);
    applyStimulus();
    checkResult("v1", 1'b1, 4'd0, cycles);
    checkOutput("v1_card_hc", 32'(card_hc_o), 32'd0);
    checkOutput("v1_card_v2", 32'(card_v2_o), 32'd0);
    checkOutput("v1_rca", 32'(card_rca_o), 32'hABCD);
    checkOutput("v1_ocr", ocr_o, 32'h80FF_8000);

    $display("[TB] scenario: bad CMD8 echo");
    startInit();
    addStep(K_DONE, 32'h0,          6'd0,  32'h0);
    addStep(K_DONE, 32'h0000_01AB,  6'd8,  32'h0000_01AA);
    applyStimulus();
    checkResult("bad_echo", 1'b0, 4'd2, cycles);
    checkOutput("bad_echo_card_v2", 32'(card_v2_o), 32'd0);
    checkNoStarts("bad_echo", 30);

    $display("[TB] scenario: ACMD41 never ready");
    startInit();
    addStep(K_DONE, 32'h0,          6'd0,  32'h0);
    addStep(K_DONE, 32'h0000_01AA,  6'd8,  32'h0000_01AA);
    for (int t = 0; t < MAX_TRIES; t++) begin
      addStep(K_DONE, 32'h0000_0120, 6'd55, 32'h0);
      addStep(K_DONE, 32'h00FF_8000 + 32'(t), 6'd41, 32'h40FF_8000);
    end
    applyStimulus();
    checkResult("acmd41_limit", 1'b0, 4'd4, cycles);
    checkOutput("acmd41_limit_ocr", ocr_o, 32'h00FF_8002);
    checkNoStarts("acmd41_limit", 30);

    $display("[TB] scenario: engine silent after CMD3");
    startInit();
    addStep(K_DONE,   32'h0,          6'd0,  32'h0);
    addStep(K_DONE,   32'h0000_01AA,  6'd8,  32'h0000_01AA);
    addStep(K_DONE,   32'h0000_0120,  6'd55, 32'h0);
    addStep(K_DONE,   32'hC0FF_8000,  6'd41, 32'h40FF_8000);
    addStep(K_DONE,   32'h0,          6'd2,  32'h0);
    addStep(K_SILENT, 32'h0,          6'd3,  32'h0);
    applyStimulus();
    checkResult("watchdog", 1'b0, 4'd7, cycles);
    checkRange("watchdog_cycles_after_start", cycles + 1, WDOG, WDOG + 2);

    $display("[TB] scenario: timeout and done together on CMD55");
    startInit();
    addStep(K_DONE,    32'h0,          6'd0,  32'h0);
    addStep(K_DONE,    32'h0000_01AA,  6'd8,  32'h0000_01AA);
    addStep(K_TO_DONE, 32'h0000_0120,  6'd55, 32'h0);
    applyStimulus();
    checkResult("cmd55_timeout", 1'b0, 4'd5, cycles);

    $display("[TB] scenario: reset during ACMD41 wait");
    startInit();
    addStep(K_DONE,   32'h0,          6'd0,  32'h0);
    addStep(K_DONE,   32'h0000_01AA,  6'd8,  32'h0000_01AA);
    addStep(K_DONE,   32'h0000_0120,  6'd55, 32'h0);
    addStep(K_SILENT, 32'h0,          6'd41, 32'h40FF_8000);
    applyStimulus();
    @(negedge PCLK_i);
    checkOutput("pre_reset_busy_v2", 32'({init_busy_o, card_v2_o}), 32'd3);
    PRESET_i = 1'b1;
    @(negedge PCLK_i);
    checkOutput("midreset_flags", 32'({init_busy_o, init_done_o, init_error_o, cmd_start_o, card_hc_o, card_v2_o}), 32'd0);
    checkOutput("midreset_index_arg", cmd_argument_o | 32'(cmd_index_o), 32'd0);
    checkOutput("midreset_ocr_rca_code", ocr_o | 32'(card_rca_o) | 32'(err_code_o), 32'd0);
    PRESET_i = 1'b0;
    pulses = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge PCLK_i);
      if (init_done_o || init_error_o) pulses++;
    end
    checkOutput("midreset_no_pulse", 32'(pulses), 32'd0);

    @(negedge PCLK_i) init_start_i = 1'b1;
    @(negedge PCLK_i) init_start_i = 1'b0;
    cycles = -1;
    for (int i = 1; i <= 100; i++) begin
      if (cmd_start_o) begin cycles = i; break; end
      @(negedge PCLK_i);
    end
    checkRange("restart_gap_cycles", cycles, GAP, GAP + 2);
    checkOutput("restart_index", 32'(cmd_index_o), 32'd0);
    checkOutput("restart_argument", cmd_argument_o, 32'h0);
    @(negedge PCLK_i);
    checkOutput("restart_start_width", 32'(cmd_start_o), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
